// File: rtl/sr_readback_check_pkg.sv
// sr_pkg: FSM encoding and FIFO word-layout helpers shared by the readback checker.
// The last-word mask marks which payload bits of the final word carry image data.
package sr_pkg;

  typedef enum logic [1:0] {IDLE, REQ, CAP, FIN} state_t;

  localparam int PAY_LSB  = 0;
  localparam int MASK_MAX = 64;

  function automatic int nwords(input int width, input int vw);
    return (width + vw - 1) / vw;
  endfunction

  // The word index sits directly above the payload.
  function automatic int idx_lsb(input int vw);
    return PAY_LSB + vw;
  endfunction

  function automatic logic [MASK_MAX-1:0] pad_mask(input int width, input int vw);
    int nb;
    logic [MASK_MAX-1:0] m;
    nb = width - (nwords(width, vw) - 1) * vw;
    m  = '0;
    for (int k = 0; k < MASK_MAX; k++) begin
      if (k < nb) m[k] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/sr_readback_check_if.sv
// Readback FIFO read port: the checker is the master (issues reads), the FIFO is the slave.
interface sr_readback_check_if #(
  parameter int FIFO_WIDTH = 36
);
  logic                  fifo_empty;
  logic [FIFO_WIDTH-1:0] fifo_q;
  logic                  fifo_rd_en;

  modport master (input fifo_empty, input fifo_q, output fifo_rd_en);
  modport slave  (output fifo_empty, output fifo_q, input fifo_rd_en);
endinterface

// File: rtl/sr_readback_check_expect_shift.sv
// sr_expect_shift: expected-image shift register fed by the configuration write stream.
// Writes are dropped while a check is running so the reference stays stable.
module sr_expect_shift #(
  parameter int WIDTH = 170
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic             i_busy,
  input  logic [15:0]      i_din,
  output logic [WIDTH-1:0] o_exp
);

  logic [WIDTH-1:0] r_exp;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_exp <= '0;
    end else if (i_wr_en && !i_busy) begin
      r_exp <= {r_exp[WIDTH-17:0], i_din};
    end
  end

  assign o_exp = r_exp;

endmodule

// File: rtl/sr_readback_check.sv
// sr_readback_check: drains the readback FIFO, rebuilds the image and compares it with the
// captured configuration stream. Define SR_CHECK_TIMEOUT_EN to abort after TIMEOUT idle cycles.
module sr_readback_check
  import sr_pkg::*;
#(
  parameter int WIDTH       = 170,
  parameter int VALID_WIDTH = 32,
  parameter int NUM_WIDTH   = 4,
  parameter int FIFO_WIDTH  = 36,
  parameter int TIMEOUT     = 1024
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  exp_wr_en,
  input  logic [15:0]           exp_din,
  input  logic                  arm,
  sr_readback_check_if.master   fifo,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [NUM_WIDTH-1:0]  err_count,
  output logic [NUM_WIDTH-1:0]  first_err,
  output logic [WIDTH-1:0]      readback
);

  localparam int                    NWORDS    = nwords(WIDTH, VALID_WIDTH);
  localparam int                    IDX_LSB   = idx_lsb(VALID_WIDTH);
  localparam logic [MASK_MAX-1:0]   LAST_MASK = pad_mask(WIDTH, VALID_WIDTH);
  localparam logic [NUM_WIDTH-1:0]  LAST_IDX  = NUM_WIDTH'(NWORDS - 1);
  localparam logic [NUM_WIDTH-1:0]  NO_ERR    = '1;

  state_t                        r_state, w_state_next;
  logic [NUM_WIDTH-1:0]          r_wcnt, r_err_count, r_first_err;
  logic                          r_pass, r_timeout;
  logic [WIDTH-1:0]              w_exp;
  logic [NWORDS*VALID_WIDTH-1:0] w_exp_pad;
  logic [VALID_WIDTH-1:0]        w_exp_word, w_pay, w_mask;
  logic [NUM_WIDTH-1:0]          w_idx;
  logic                          w_word_bad, w_rd_en, w_tmo_hit, w_pass_now;

  sr_expect_shift #(.WIDTH(WIDTH)) u_expect (
    .clk_in  (clk_in),
    .rst     (rst),
    .i_wr_en (exp_wr_en),
    .i_busy  (busy),
    .i_din   (exp_din),
    .o_exp   (w_exp)
  );

  assign w_pay = fifo.fifo_q[PAY_LSB +: VALID_WIDTH];
  assign w_idx = fifo.fifo_q[FIFO_WIDTH-1:IDX_LSB];

  always_comb begin
    w_exp_pad              = '0;
    w_exp_pad[WIDTH-1:0]   = w_exp;
    w_exp_word             = '0;
    for (int k = 0; k < NWORDS; k++) begin
      if (r_wcnt == NUM_WIDTH'(k)) w_exp_word = w_exp_pad[k*VALID_WIDTH +: VALID_WIDTH];
    end
    w_mask     = (r_wcnt == LAST_IDX) ? LAST_MASK[VALID_WIDTH-1:0] : '1;
    w_word_bad = (w_idx != r_wcnt) || (((w_pay ^ w_exp_word) & w_mask) != '0);
  end

`ifdef SR_CHECK_TIMEOUT_EN
  logic [15:0] r_idle;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_idle <= '0;
    end else if (r_state == REQ && fifo.fifo_empty) begin
      r_idle <= r_idle + 16'd1;
    end else begin
      r_idle <= '0;
    end
  end

  assign w_tmo_hit = (r_state == REQ) && fifo.fifo_empty && (r_idle == 16'(TIMEOUT));
`else
  // Never true; the abort path does not exist in this build.
  assign w_tmo_hit = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk_in) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    case (r_state)
      IDLE: if (arm) w_state_next = REQ;
      REQ: begin
        if (w_tmo_hit) begin
          w_state_next = FIN;
        end else if (!fifo.fifo_empty && !rst) begin
          w_rd_en      = 1'b1;
          w_state_next = CAP;
        end
      end
      CAP:     w_state_next = (r_wcnt == LAST_IDX) ? FIN : REQ;
      FIN:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_wcnt      <= '0;
      r_err_count <= '0;
      r_first_err <= NO_ERR;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (arm) begin
          r_wcnt      <= '0;
          r_err_count <= '0;
          r_first_err <= NO_ERR;
          r_pass      <= 1'b0;
          r_timeout   <= 1'b0;
        end
        REQ: if (w_tmo_hit) r_timeout <= 1'b1;
        CAP: begin
          r_wcnt <= r_wcnt + 1'b1;
          if (w_word_bad) begin
            r_err_count <= r_err_count + 1'b1;
            if (r_first_err == NO_ERR) r_first_err <= r_wcnt;
          end
        end
        FIN:     r_pass <= w_pass_now;
        default: ;
      endcase
    end
  end

  // One register per FIFO word; the last one keeps only the unpadded bits.
  for (genvar gi = 0; gi < NWORDS; gi++) begin : g_rb
    localparam int LO = gi * VALID_WIDTH;
    localparam int W  = ((WIDTH - LO) < VALID_WIDTH) ? (WIDTH - LO) : VALID_WIDTH;
    logic [W-1:0] r_slice;

    always_ff @(posedge clk_in) begin
      if (rst) begin
        r_slice <= '0;
      end else if (r_state == CAP && r_wcnt == NUM_WIDTH'(gi)) begin
        r_slice <= w_pay[W-1:0];
      end
    end

    assign readback[LO+W-1:LO] = r_slice;
  end

  assign w_pass_now      = (r_err_count == '0) && !r_timeout;
  assign fifo.fifo_rd_en = w_rd_en;
  assign busy            = (r_state != IDLE);
  assign done            = (r_state == FIN);
  assign pass            = (r_state == FIN) ? w_pass_now : r_pass;
  assign timeout         = r_timeout;
  assign err_count       = r_err_count;
  assign first_err       = r_first_err;

endmodule

// File: tb/tb_sr_readback_check.sv
// Bench for sr_readback_check: FIFO model fed from a queue, reference image kept as a plain vector.
// Build with SR_CHECK_TIMEOUT_EN to also exercise the timeout abort (TIMEOUT=20).
module tb_sr_readback_check;

`ifdef SR_CHECK_TIMEOUT_EN
  localparam int TB_TIMEOUT = 20;
  localparam int STALL_LEN  = 15;
`else
  localparam int TB_TIMEOUT = 1024;
  localparam int STALL_LEN  = 50;
`endif

  logic         clk_in = 1'b0;
  logic         rst, exp_wr_en, arm;
  logic [15:0]  exp_din;
  logic         busy, done, pass, timeout;
  logic [3:0]   err_count, first_err;
  logic [169:0] readback;

  sr_readback_check_if #(.FIFO_WIDTH(36)) fifo_if ();

  sr_readback_check #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .exp_wr_en (exp_wr_en),
    .exp_din   (exp_din),
    .arm       (arm),
    .fifo      (fifo_if),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .timeout   (timeout),
    .err_count (err_count),
    .first_err (first_err),
    .readback  (readback)
  );

  always #5 clk_in = ~clk_in;

  int           n_checks = 0, n_errors = 0;
  int           cyc = 0, arm_ref = 0, stall_lo = 0, stall_n = 0;
  logic [35:0]  fq[$];
  logic [35:0]  words[6];
  logic [169:0] m_exp;

  // Standard FIFO: data appears the cycle after the read strobe.
  always @(posedge clk_in) begin
    if (fifo_if.fifo_rd_en && !fifo_if.fifo_empty && fq.size() > 0)
      fifo_if.fifo_q <= fq.pop_front();
  end

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    int rel;
    @(posedge clk_in);
    #1;
    cyc++;
    rel = cyc - arm_ref;
    fifo_if.fifo_empty = (fq.size() == 0) || (rel >= stall_lo && rel < stall_lo + stall_n);
    #1;
  endtask

  task automatic write_exp(input logic [15:0] d);
    exp_wr_en = 1'b1;
    exp_din   = d;
    tick();
    exp_wr_en = 1'b0;
    m_exp     = {m_exp[153:0], d};
  endtask

  task automatic make_words();
    for (int i = 0; i < 6; i++) begin
      words[i] = '0;
      words[i][35:32] = 4'(i);
      for (int b = 0; b < 32; b++)
        if (32 * i + b < 170) words[i][b] = m_exp[32*i+b];
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " busy"},      192'(busy),              192'(0));
    check({tag, " done"},      192'(done),              192'(0));
    check({tag, " pass"},      192'(pass),              192'(0));
    check({tag, " timeout"},   192'(timeout),           192'(0));
    check({tag, " rd_en"},     192'(fifo_if.fifo_rd_en), 192'(0));
    check({tag, " err_count"}, 192'(err_count),         192'(0));
    check({tag, " first_err"}, 192'(first_err),         192'(4'hF));
    check({tag, " readback"},  192'(readback),          192'(0));
  endtask

  // Reference: classify each word from its index field and unpadded payload bits.
  task automatic run_check(input string name, input int stall_w, input int stall_len, input bit poke);
    int           e_errs, lat, rd_stall, nb;
    logic [3:0]   e_first;
    logic [169:0] e_rb;
    bit           bad, seen;
    e_errs = 0; e_first = 4'hF; e_rb = '0;
    for (int i = 0; i < 6; i++) begin
      nb  = (i == 5) ? 10 : 32;
      bad = (words[i][35:32] != 4'(i));
      for (int b = 0; b < nb; b++) begin
        if (words[i][b] != m_exp[32*i+b]) bad = 1'b1;
        e_rb[32*i+b] = words[i][b];
      end
      if (bad) begin
        e_errs++;
        if (e_first == 4'hF) e_first = 4'(i);
      end
    end
    for (int i = 0; i < 6; i++) fq.push_back(words[i]);
    stall_lo = 1 + 2 * stall_w;
    stall_n  = stall_len;
    arm      = 1'b1;
    arm_ref  = cyc;
    lat = 0; seen = 1'b0; rd_stall = 0;
    while (!seen && lat < 300) begin
      tick();
      lat++;
      if (lat == 1) arm = 1'b0;
      if (lat >= stall_lo && lat < stall_lo + stall_n && fifo_if.fifo_rd_en) rd_stall++;
      if (poke && lat == stall_lo + 3) begin
        arm = 1'b1; exp_wr_en = 1'b1; exp_din = 16'hDEAD;
      end else if (poke && lat == stall_lo + 4) begin
        arm = 1'b0; exp_wr_en = 1'b0;
      end
      if (done) seen = 1'b1;
    end
    check({name, " latency"},   192'(lat),       192'(13 + stall_len));
    check({name, " pass"},      192'(pass),      192'(e_errs == 0));
    check({name, " err_count"}, 192'(err_count), 192'(e_errs));
    check({name, " first_err"}, 192'(first_err), 192'(e_first));
    check({name, " timeout"},   192'(timeout),   192'(0));
    check({name, " readback"},  192'(readback),  192'(e_rb));
    if (stall_len > 0) check({name, " rd_en in stall"}, 192'(rd_stall), 192'(0));
    stall_n = 0;
    tick();
    check({name, " done pulse"}, 192'(done),      192'(0));
    check({name, " idle"},       192'(busy),      192'(0));
    check({name, " pass hold"},  192'(pass),      192'(e_errs == 0));
    check({name, " drained"},    192'(fq.size()), 192'(0));
    $display("txn %-10s lat=%0d pass=%0b err_count=%0d first_err=%0h (model errs=%0d first=%0h)",
             name, lat, pass, err_count, first_err, e_errs, e_first);
  endtask

  initial begin
    int sw, sl, lat;
    rst = 1'b1; arm = 1'b0; exp_wr_en = 1'b0; exp_din = '0;
    fifo_if.fifo_empty = 1'b1; fifo_if.fifo_q = '0;
    m_exp = '0;
    repeat (3) tick();
    check_reset_state("reset");
    rst = 1'b0;
    tick();

    for (int k = 1; k <= 11; k++) write_exp(16'(k));

    make_words();
    run_check("basic", 0, 0, 1'b0);
    check("basic readback==exp", 192'(readback), 192'(m_exp));

    make_words();
    words[2][5] = ~words[2][5];
    words[4][0] = ~words[4][0];
    run_check("payload", 0, 0, 1'b0);

    make_words();
    words[3][35:32] = 4'd7;
    run_check("index", 0, 0, 1'b0);

    make_words();
    words[5][31:10] = '1;
    run_check("padding", 0, 0, 1'b0);

    make_words();
    run_check("stall", 2, STALL_LEN, 1'b1);

    // A write during the stall must not have reached the expected image.
    make_words();
    run_check("post-stall", 0, 0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < 11; k++) write_exp(16'($urandom));
      make_words();
      for (int i = 0; i < 6; i++) begin
        if ($urandom_range(3) == 0) words[i][$urandom_range(31)] ^= 1'b1;
        if ($urandom_range(7) == 0) words[i][35:32] = 4'($urandom_range(15));
      end
      if ($urandom_range(1) == 1) words[5][31:10] = 22'($urandom);
      sw = $urandom_range(1, 5);
      sl = $urandom_range(0, 10);
      run_check($sformatf("rand%0d", t), sw, sl, 1'b0);
    end

`ifdef SR_CHECK_TIMEOUT_EN
    arm = 1'b1; arm_ref = cyc; lat = 0;
    while (!done && lat < 200) begin
      tick();
      lat++;
      if (lat == 1) arm = 1'b0;
    end
    check("tmo latency", 192'(lat),     192'(TB_TIMEOUT + 2));
    check("tmo flag",    192'(timeout), 192'(1));
    check("tmo pass",    192'(pass),    192'(0));
    tick();
    check("tmo hold",    192'(timeout), 192'(1));
    $display("txn timeout    lat=%0d timeout=%0b pass=%0b", lat, timeout, pass);
`endif

    // Reset after two words: the FSM idles and the rest of the FIFO is left alone.
    make_words();
    for (int i = 0; i < 6; i++) fq.push_back(words[i]);
    arm = 1'b1; arm_ref = cyc;
    tick();
    arm = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("rst busy",    192'(busy),      192'(0));
    tick();
    check("rst fifo kept", 192'(fq.size()), 192'(4));
    check_reset_state("rst mid");
    $display("txn reset-mid  busy=%0b fifo_left=%0d", busy, fq.size());
    rst = 1'b0;
    fq.delete();
    m_exp = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/sr_readback_check.md
# sr_readback_check

Self-check stage directly downstream of the TMIIa shift-register read path. It drains the 36-bit words that the shift-register block leaves in its readback FIFO and reassembles the 170-bit readback image. It compares that image against an expected pattern captured from the same 16-bit configuration writes, then reports pass/fail, an error count and the first failing word index. It sits between the shift-register block's FIFO read port and the control interface.

## Interface
Parameters:
- WIDTH, 170, shift-register image width
- VALID_WIDTH, 32, payload bits per FIFO word
- NUM_WIDTH, 4, word-index field width; 2**NUM_WIDTH > ceil(WIDTH/VALID_WIDTH)
- FIFO_WIDTH, 36, FIFO word width, = NUM_WIDTH+VALID_WIDTH
- TIMEOUT, 1024, idle-FIFO cycles before abort (timeout build only)

Ports:
- clk_in  in  1  single clock, same as FIFO rd_clk
- rst  in  1  reset, synchronous, active-high
- exp_wr_en  in  1  capture exp_din into expected image
- exp_din  in  16  configuration word, same stream as the shift-register din
- arm  in  1  one-cycle pulse that starts a check (tie to start)
- fifo_empty  in  1  readback FIFO empty
- fifo_q  in  FIFO_WIDTH  readback FIFO data, valid the cycle after fifo_rd_en
- fifo_rd_en  out  1  FIFO read strobe
- busy  out  1  check in progress
- done  out  1  one-cycle pulse at check end
- pass  out  1  last check had zero errors and no timeout
- timeout  out  1  last check aborted on timeout
- err_count  out  NUM_WIDTH  failing words in last check
- first_err  out  NUM_WIDTH  index of first failing word; all-ones if none
- readback  out  WIDTH  reassembled image

## Operation
- NWORDS = ceil(WIDTH/VALID_WIDTH) = 6. Word i format: fifo_q[35:32] = i, fifo_q[31:0] = image bits [32i+31:32i]. Bits above WIDTH-1 in word 5 are padding and are ignored.
- Expected image: on exp_wr_en, exp = {exp[WIDTH-17:0], exp_din}. This is accepted only when busy=0 and is ignored while busy. It is not cleared by arm.
- FSM states:
  - IDLE: on arm, clear err_count, first_err, timeout and word counter wcnt, then go to REQ.
  - REQ: if !fifo_empty, assert fifo_rd_en for 1 cycle and go to CAP. Otherwise stay.
  - CAP: store fifo_q[31:0] into readback slice wcnt.
    - The word fails if the index field ≠ wcnt or the payload ≠ the exp slice (unpadded bits only).
    - On a failure: err_count+1; first_err=wcnt if still all-ones.
    - wcnt+1. If wcnt was NWORDS-1, go to FIN; else go to REQ.
  - FIN: done=1, pass=(err_count==0 && !timeout), go to IDLE.
- arm while busy is ignored.
- The FIFO is never read outside REQ. At most one outstanding read.
- Reset mid-check: FSM to IDLE; any partially read words stay in the FIFO and are not discarded.

## Timing
- Reset values:
  - fifo_rd_en, busy, done, pass, timeout = 0
  - err_count = 0
  - first_err = all-ones
  - readback = 0
  - exp = 0
- busy=1 from the cycle after arm until the FIN cycle inclusive.
- Throughput: one word per 2 cycles. With the FIFO never empty, done asserts in cycle arm+13.
- pass, err_count, first_err, timeout and readback hold until the next arm.
- The fifo_q sample in CAP relies on the standard (non-FWFT) FIFO, whose read latency is 1.

## Configuration
- SR_CHECK_TIMEOUT_EN defined:
  - A 16-bit idle counter runs in REQ while fifo_empty=1 and resets on each read.
  - At TIMEOUT, set timeout=1 and go to FIN (done pulses, pass=0).
- Undefined: no counter; timeout is tied to 0 and REQ waits indefinitely.

## Structure
- Package sr_pkg:
  - state enum (IDLE, REQ, CAP, FIN)
  - NWORDS function
  - index/payload field positions
  - padding-mask function for the last word
- One sub-module, sr_expect_shift: the expected-image 16-bit shift register with busy gating.

## Test plan
- Basic pass: write eleven 16-bit words 0x0001..0x000B, then arm. Preload the FIFO with the 6 matching words. Required: done at arm+13, pass=1, err_count=0, first_err=0xF, readback==exp.
- Payload error: same as basic pass, but flip bit 5 of word 2 and bit 0 of word 4. Required: pass=0, err_count=2, first_err=2.
- Index error: same as basic pass, but word 3 carries index 7 with a correct payload. Required: err_count=1, first_err=3.
- Padding ignored: word 5 with bits [31:10] = all-ones and correct bits [9:0]. Required: pass=1.
- Stalled FIFO: FIFO empty for 50 cycles between words 1 and 2. Required: fifo_rd_en stays low during the stall, done at arm+63, pass=1. A second arm during the stall is ignored. An exp_wr_en during the stall leaves exp unchanged.
- Timeout (with SR_CHECK_TIMEOUT_EN, TIMEOUT=20): arm with the FIFO empty. Required: done 22 cycles after arm, timeout=1, pass=0. rst mid-check returns busy=0 on the next cycle.
